// File: rtl/fft_r22sdf_pkg.sv
// Shared definitions for the R2^2 SDF FFT frame sequencer.
//   - err_cause_t   : why err_o fired (gap, sof mid-frame, misaligned sample)
//   - frame_state_t : input-side frame FSM states
//   - clog2, bitrev : elaboration/combinational helpers
//   - dly_len, dly_tap : sizing and tap position of the slot-flag delay line
package fft_r22sdf_pkg;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_GAP      = 2'd1,
      ERR_SOF_MID  = 2'd2,
      ERR_MISALIGN = 2'd3
   } err_cause_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } frame_state_t;

   function automatic int clog2(input int val);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < val) r = i + 1;
      end
      return r;
   endfunction

   // Reverses the low 'width' bits of val; upper result bits are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) r = (r << 1) | ((val >> i) & 32'd1);
      end
      return r;
   endfunction

   // Slot flags held: enough whole slots to span the pipeline latency, plus one.
   function automatic int dly_len(input int n, input int lat);
      return ((lat + n) / n) + 1;
   endfunction

   // Tap into {delay_line, live_flag}: 0 selects the flag of the slot still
   // being filled, m selects the slot completed m slots ago.
   function automatic int dly_tap(input int n, input int lat);
      return (lat - 1) / n;
   endfunction

endpackage

// File: rtl/fft_r22sdf_frame_dly.sv
// Slot-flag delay line.
// At every slot wrap the final "frame fully accepted" flag of the slot is
// shifted in. tap_o selects either the live flag (tap 0) or one of the stored
// flags, so the output side can look up the slot that started PIPE_LAT cycles
// before its own slot boundary.
//   clk_i, rst_i : clock, async active-high reset
//   push_i       : slot wrap (last cycle of a slot)
//   flag_i       : live slot flag, already including this cycle's update
//   tap_sel_i    : tap position into {dly_q, flag_i}
//   tap_o        : selected flag
module fft_r22sdf_frame_dly
   import fft_r22sdf_pkg::*;
#(
   parameter int K     = 3,
   parameter int SEL_W = clog2(K + 1)
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             flag_i,
   input  logic [SEL_W-1:0] tap_sel_i,
   output logic             tap_o
);

   logic [K-1:0] dly_q;
   logic [K-1:0] dly_d;
   logic [K:0]   line;

   always_comb begin
      dly_d = dly_q;
      if (push_i) dly_d = {dly_q[K-2:0], flag_i};
   end

   assign line  = {dly_q, flag_i};
   assign tap_o = line[tap_sel_i];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) dly_q <= '0;
      else       dly_q <= dly_d;
   end

endmodule

// File: rtl/fft_r22sdf_ctrl.sv
// Frame sequencer for the radix-2^2 single-delay-feedback FFT pipeline.
// A free-running slot counter drives stage 1; frames are admitted only at
// cnt_o==0 and any slot without a complete frame is zero-filled. The output
// side runs a second counter offset by PIPE_LAT and tags pipeline output with
// valid, bit-reversed bin index and last.
//   clk_i, rst_i      : clock, async active-high reset
//   valid_i, sof_i    : input sample present / first sample of frame
//   ready_o           : a frame may start (cnt_o==0) or one is in progress
//   cnt_o             : slot sample counter into stage 1
//   zero_o            : registered with the input sample; 1 forces 0+j0 for
//                       the sample taken on the previous cycle
//   valid_o/idx_o/last_o : output tags, aligned with the registered output
//   err_o             : one-cycle pulse on a protocol violation
//
// state    | meaning
// ST_IDLE  | no frame in progress; only sof at cnt 0 is accepted
// ST_FRAME | frame accepted this slot; each cycle needs valid_i & !sof_i
module fft_r22sdf_ctrl
   import fft_r22sdf_pkg::*;
#(
   parameter int FFT_N     = 1024,
   parameter int FFT_NLOG2 = 10,
   parameter int PIPE_LAT  = 1023
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic                 sof_i,
   output logic                 ready_o,
   output logic [FFT_NLOG2-1:0] cnt_o,
   output logic                 zero_o,
   output logic                 valid_o,
   output logic [FFT_NLOG2-1:0] idx_o,
   output logic                 last_o,
   output logic                 err_o
);

   localparam int K     = dly_len(FFT_N, PIPE_LAT);
   localparam int SEL_W = clog2(K + 1);
   localparam logic [SEL_W-1:0]     TAP_SEL  = SEL_W'(dly_tap(FFT_N, PIPE_LAT));
   localparam logic [FFT_NLOG2-1:0] CNT_MAX  = FFT_NLOG2'(FFT_N - 1);
   // ocnt = (t - PIPE_LAT) mod FFT_N, so it starts PIPE_LAT behind cnt.
   localparam logic [FFT_NLOG2-1:0] OCNT_RST = FFT_NLOG2'((FFT_N - (PIPE_LAT % FFT_N)) % FFT_N);

   frame_state_t         state_q, state_d;
   logic [FFT_NLOG2-1:0] cnt_q, cnt_d;
   logic                 slot_q, slot_d;
   logic                 zero_q, zero_d;
   logic                 err_q, err_d;
   logic [FFT_NLOG2-1:0] ocnt_q, ocnt_d;
   logic                 out_frame_ok_q, out_frame_ok_d;
   logic [FFT_NLOG2-1:0] idx_q, idx_d;
   logic                 last_q, last_d;

   logic       accept;
   logic       pass;
   err_cause_t cause;
   logic       push;
   logic       tap;

   always_comb begin
      state_d = state_q;
      pass    = 1'b0;
      cause   = ERR_NONE;
      accept  = valid_i & sof_i & (cnt_q == '0);
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               pass    = 1'b1;
               state_d = ST_FRAME;
            end else if (valid_i) begin
               cause = ERR_MISALIGN;
            end
         end
         ST_FRAME: begin
            if (!valid_i) begin
               cause   = ERR_GAP;
               state_d = ST_IDLE;
            end else if (sof_i) begin
               cause   = ERR_SOF_MID;
               state_d = ST_IDLE;
            end else begin
               pass = 1'b1;
               if (cnt_q == CNT_MAX) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      // Slot flag: set only by an accept at slot start, dropped by any abort.
      slot_d = slot_q;
      if (cnt_q == '0)                                  slot_d = accept;
      else if (cause == ERR_GAP || cause == ERR_SOF_MID) slot_d = 1'b0;
      zero_d = ~pass;
      err_d  = (cause != ERR_NONE);
      push   = (cnt_q == CNT_MAX);
   end

   fft_r22sdf_frame_dly #(
      .K     (K),
      .SEL_W (SEL_W)
   ) u_frame_dly (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push),
      .flag_i    (slot_d),
      .tap_sel_i (TAP_SEL),
      .tap_o     (tap)
   );

   always_comb begin
      ocnt_d         = (ocnt_q == CNT_MAX) ? '0 : ocnt_q + 1'b1;
      out_frame_ok_d = out_frame_ok_q;
      // Latch on the edge into ocnt==0 so valid_o covers the whole output slot.
      if (ocnt_q == CNT_MAX) out_frame_ok_d = tap;
      last_d = out_frame_ok_d & (ocnt_d == CNT_MAX);
      idx_d  = FFT_NLOG2'(bitrev(32'(ocnt_d), FFT_NLOG2));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         slot_q         <= 1'b0;
         zero_q         <= 1'b1;
         err_q          <= 1'b0;
         ocnt_q         <= OCNT_RST;
         out_frame_ok_q <= 1'b0;
         idx_q          <= '0;
         last_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         slot_q         <= slot_d;
         zero_q         <= zero_d;
         err_q          <= err_d;
         ocnt_q         <= ocnt_d;
         out_frame_ok_q <= out_frame_ok_d;
         idx_q          <= idx_d;
         last_q         <= last_d;
      end
   end

   assign ready_o = (cnt_q == '0) | (state_q == ST_FRAME);
   assign cnt_o   = cnt_q;
   assign zero_o  = zero_q;
   assign err_o   = err_q;
   assign valid_o = out_frame_ok_q;
   assign idx_o   = idx_q;
   assign last_o  = last_q;

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Scoreboard bench for fft_r22sdf_ctrl (N=16, PIPE_LAT=20).
// The reference model works on the recorded input history: which slots hold a
// complete frame, whether a sample belongs to a running frame, and where that
// frame's output lands in time.
module tb_fft_r22sdf_ctrl;

   localparam int N   = 16;
   localparam int LOG = 4;
   localparam int L   = 20;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           valid_i;
   logic           sof_i;
   logic           ready_o;
   logic [LOG-1:0] cnt_o;
   logic           zero_o;
   logic           valid_o;
   logic [LOG-1:0] idx_o;
   logic           last_o;
   logic           err_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int t;
      int cnt;
      bit zero;
      bit err;
      bit ready;
      bit valid;
      bit last;
   } rec_t;

   typedef struct {
      int t;
      int idx;
      bit last;
   } out_t;

   rec_t expq[$];
   out_t outq[$];
   bit   vq[$];
   bit   sq[$];
   int   t;
   bit   mon_en = 1'b0;

   fft_r22sdf_ctrl #(.FFT_N(N), .FFT_NLOG2(LOG), .PIPE_LAT(L)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .sof_i   (sof_i),
      .ready_o (ready_o),
      .cnt_o   (cnt_o),
      .zero_o  (zero_o),
      .valid_o (valid_o),
      .idx_o   (idx_o),
      .last_o  (last_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int tt, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%0d want=%0d", name, tt, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int md(input int a);
      return ((a % N) + N) % N;
   endfunction

   function automatic bit clean(input int u);
      return vq[u] && !sq[u];
   endfunction

   function automatic bit started(input int j);
      return vq[j*N] && sq[j*N];
   endfunction

   // Sample u falls inside a frame that is still intact before u.
   function automatic bit in_frame_before(input int u);
      int j;
      if (u % N == 0) return 1'b0;
      j = u / N;
      if (!started(j)) return 1'b0;
      for (int w = j*N + 1; w < u; w++) if (!clean(w)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit slot_ok(input int j);
      return started(j) && in_frame_before(j*N + N - 1) && clean(j*N + N - 1);
   endfunction

   function automatic int brev(input int i);
      int r;
      r = 0;
      for (int b = 0; b < LOG; b++) r = r*2 + ((i >> b) & 1);
      return r;
   endfunction

   // Expected outputs during cycle u, using inputs of cycles 0..u-1.
   function automatic rec_t expect_at(input int u);
      rec_t r;
      int   o, s;
      r.t   = u;
      r.cnt = u % N;
      if (u == 0) begin
         r.zero = 1'b1;
         r.err  = 1'b0;
      end else begin
         r.zero = !(((u-1) % N == 0) ? started((u-1) / N)
                                     : (in_frame_before(u-1) && clean(u-1)));
         r.err  = in_frame_before(u-1) ? !clean(u-1)
                                       : (vq[u-1] && !(sq[u-1] && ((u-1) % N == 0)));
      end
      r.ready = (u % N == 0) || in_frame_before(u);
      o       = md(u - L);
      s       = u - L - o;
      r.valid = (s >= 0) && slot_ok(s / N);
      r.last  = r.valid && (o == N - 1);
      return r;
   endfunction

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit s);
      out_t e;
      @(negedge clk_i);
      valid_i = v;
      sof_i   = s;
      vq.push_back(v);
      sq.push_back(s);
      if ((t % N == N - 1) && slot_ok(t / N)) begin
         for (int i = 0; i < N; i++) begin
            e.t    = (t / N) * N + L + i;
            e.idx  = brev(i);
            e.last = (i == N - 1);
            outq.push_back(e);
         end
      end
      t++;
      expq.push_back(expect_at(t));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
   endtask

   task automatic align();
      while (t % N != 0) drive(1'b0, 1'b0);
   endtask

   // kind 1: valid gap, kind 2: sof mid-frame; abort_at 0 means a clean frame.
   task automatic frame(input int abort_at, input int kind, input bit noise);
      bit aborted;
      aborted = 1'b0;
      drive(1'b1, 1'b1);
      for (int i = 1; i < N; i++) begin
         if (i == abort_at) begin
            aborted = 1'b1;
            if (kind == 1) drive(1'b0, 1'($urandom % 2));
            else           drive(1'b1, 1'b1);
         end else if (!aborted) begin
            drive(1'b1, 1'b0);
         end else if (noise) begin
            drive(($urandom % 3) == 0, 1'($urandom % 2));
         end else begin
            drive(1'b0, 1'b0);
         end
      end
   endtask

   task automatic release_reset();
      @(posedge clk_i);
      #2;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      sof_i   = 1'b0;
      t       = 0;
      vq.delete();
      sq.delete();
      expq.delete();
      outq.delete();
      expq.push_back(expect_at(0));
      mon_en = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk_i);
         if (mon_en) begin
            rec_t r;
            out_t o;
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL exp_underflow got=empty want=record");
            end else begin
               r = expq.pop_front();
               chk("cnt",   r.t, 32'(cnt_o),   32'(r.cnt));
               chk("zero",  r.t, 32'(zero_o),  32'(r.zero));
               chk("err",   r.t, 32'(err_o),   32'(r.err));
               chk("ready", r.t, 32'(ready_o), 32'(r.ready));
               chk("valid", r.t, 32'(valid_o), 32'(r.valid));
               chk("last",  r.t, 32'(last_o),  32'(r.last));
               if (valid_o === 1'b1) begin
                  if (outq.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL out_unexpected t=%0d got=valid want=none", r.t);
                  end else begin
                     o = outq.pop_front();
                     chk("out_time", r.t, 32'(r.t), 32'(o.t));
                     chk("idx",      r.t, 32'(idx_o), 32'(o.idx));
                     chk("out_last", r.t, 32'(last_o), 32'(o.last));
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0d got=running want=finished", t);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b0;
      sof_i   = 1'b0;
      t       = 0;
      repeat (3) @(posedge clk_i);
      release_reset();

      // single frame
      idle(3);
      align();
      frame(0, 0, 1'b0);
      idle(2*N);

      // back-to-back frames
      frame(0, 0, 1'b0);
      frame(0, 0, 1'b0);
      frame(0, 0, 1'b0);
      idle(2*N);

      // gap abort at cnt 5, then a clean frame in the next slot
      frame(5, 1, 1'b0);
      frame(0, 0, 1'b0);
      idle(2*N);

      // sof in mid-frame, and abort on the very last sample
      frame(9, 2, 1'b0);
      frame(N-1, 1, 1'b0);
      idle(N);

      // misaligned sof while idle
      idle(3);
      drive(1'b1, 1'b1);
      align();

      // idle stretch
      idle(100);
      align();

      // randomized slots
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0: frame(0, 0, 1'b0);
            1: frame(int'($urandom_range(1, N-1)), 1, 1'b1);
            2: frame(int'($urandom_range(1, N-1)), 2, 1'b1);
            default: for (int i = 0; i < N; i++) drive(($urandom % 4) == 0, 1'($urandom % 2));
         endcase
      end
      idle(2*N);
      align();

      // reset in mid-frame with the previous frame's output in flight
      frame(0, 0, 1'b0);
      drive(1'b1, 1'b1);
      for (int i = 1; i <= 9; i++) drive(1'b1, 1'b0);
      #2;
      rst_i  = 1'b1;
      mon_en = 1'b0;
      #1;
      chk("rst_cnt",   t, 32'(cnt_o),   32'd0);
      chk("rst_zero",  t, 32'(zero_o),  32'd1);
      chk("rst_valid", t, 32'(valid_o), 32'd0);
      chk("rst_idx",   t, 32'(idx_o),   32'd0);
      chk("rst_last",  t, 32'(last_o),  32'd0);
      chk("rst_err",   t, 32'(err_o),   32'd0);
      chk("rst_ready", t, 32'(ready_o), 32'd1);
      expq.delete();
      outq.delete();
      repeat (2) @(posedge clk_i);
      release_reset();
      idle(L + 3*N);

      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("outq_drained", t, 32'(outq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
